vending_controller_param: RTL and testbench

- Parametrised, fully sequential vending controller. Replaces the combinational next-balance calculator plus external state register with one clocked block.
- Owns the balance register and a wait-time timeout counter. Returns change with a greedy largest-coin-first FSM, one coin per cycle.
- Sits between the coin/select front-end and the dispenser/change-hopper drivers.
- Coin values and item prices are runtime inputs, so one netlist serves any price table.

---
 rtl/vending_pkg.sv | 22 ++
 rtl/vm_change_picker.sv | 42 ++++
 rtl/vending_controller_param.sv | 196 +++++++++++++++++++
 tb/tb_vending_controller_param.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared definitions for the parametrised vending controller.
// Holds the controller state encoding, default sizing, and the helper that
// sizes the wait-time down-counter. No ports.
package vending_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      RETURN = 2'd2
   } state_e;

   localparam int DEF_NUM_COINS   = 3;
   localparam int DEF_NUM_ITEMS   = 4;
   localparam int DEF_TOTAL_BITS  = 31;
   localparam int DEF_WAIT_CYCLES = 100;

   // Counter must be able to hold WAIT_CYCLES itself (the reload value).
   function automatic int timer_width(input int wait_cycles);
      return $clog2(wait_cycles + 1);
   endfunction

endpackage

// File: rtl/vm_change_picker.sv
// Combinational greedy change selector.
// Picks the coin with the largest nonzero value that still fits in the
// balance; ties go to the lowest index.
// Ports:
//   i_balance    : current balance
//   i_coin_value : packed coin values, coin k at [k*TOTAL_BITS +: TOTAL_BITS]
//   o_coin       : one-hot chosen coin (all zero when nothing fits)
//   o_value      : value of the chosen coin
//   o_valid      : a coin fits
module vm_change_picker
   import vending_pkg::*;
#(
   parameter int NUM_COINS  = DEF_NUM_COINS,
   parameter int TOTAL_BITS = DEF_TOTAL_BITS
)(
   input  logic [TOTAL_BITS-1:0]           i_balance,
   input  logic [NUM_COINS*TOTAL_BITS-1:0] i_coin_value,
   output logic [NUM_COINS-1:0]            o_coin,
   output logic [TOTAL_BITS-1:0]           o_value,
   output logic                            o_valid
);

   logic [TOTAL_BITS-1:0] val;

   always_comb begin
      o_coin  = '0;
      o_value = '0;
      o_valid = 1'b0;
      val     = '0;
      for (int k = 0; k < NUM_COINS; k++) begin
         val = i_coin_value[k*TOTAL_BITS +: TOTAL_BITS];
         // Strict '>' keeps the lowest index on equal values.
         if ((val != '0) && (val <= i_balance) && (!o_valid || (val > o_value))) begin
            o_coin    = '0;
            o_coin[k] = 1'b1;
            o_value   = val;
            o_valid   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vending_controller_param.sv
// Parametrised vending controller: balance register, idle-timeout
// down-counter and greedy change return, all in one clocked block.
// Coin values and item prices are runtime inputs.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | no session; balance 0 (or residue left after change ran out)
//   ACTIVE | balance > 0, idle timer counting down
//   RETURN | paying out change, one coin per cycle
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   i_input_coin      : one-hot coin insert (lowest index wins)
//   i_select_item     : item request (lowest available index wins)
//   i_trigger_return  : user change request
//   i_coin_value      : packed coin values
//   i_item_price      : packed item prices
//   o_available_item  : price <= balance, outside RETURN
//   o_output_item     : one-cycle dispense pulse
//   o_return_coin     : one-cycle change pulse per coin
//   o_current_total   : balance
//   o_coin_reject     : one-cycle bounced-coin pulse
//   o_returning       : state is RETURN
module vending_controller_param
   import vending_pkg::*;
#(
   parameter int NUM_COINS   = DEF_NUM_COINS,
   parameter int NUM_ITEMS   = DEF_NUM_ITEMS,
   parameter int TOTAL_BITS  = DEF_TOTAL_BITS,
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
)(
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_COINS-1:0]            i_input_coin,
   input  logic [NUM_ITEMS-1:0]            i_select_item,
   input  logic                            i_trigger_return,
   input  logic [NUM_COINS*TOTAL_BITS-1:0] i_coin_value,
   input  logic [NUM_ITEMS*TOTAL_BITS-1:0] i_item_price,
   output logic [NUM_ITEMS-1:0]            o_available_item,
   output logic [NUM_ITEMS-1:0]            o_output_item,
   output logic [NUM_COINS-1:0]            o_return_coin,
   output logic [TOTAL_BITS-1:0]           o_current_total,
   output logic                            o_coin_reject,
   output logic                            o_returning
);

   localparam int                 TIMER_W      = timer_width(WAIT_CYCLES);
   localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(WAIT_CYCLES);
   localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);

   state_e                state_q,       state_d;
   logic [TOTAL_BITS-1:0] balance_q,     balance_d;
   logic [TIMER_W-1:0]    timer_q,       timer_d;
   logic [NUM_ITEMS-1:0]  output_item_q, output_item_d;
   logic [NUM_COINS-1:0]  return_coin_q, return_coin_d;
   logic                  coin_reject_q, coin_reject_d;

   logic [NUM_ITEMS-1:0]  available;
   logic                  coin_found;
   logic [TOTAL_BITS-1:0] coin_val;
   logic [TOTAL_BITS:0]   coin_sum;
   logic                  coin_accept;
   logic                  disp_found;
   logic [NUM_ITEMS-1:0]  disp_onehot;
   logic [TOTAL_BITS-1:0] disp_price;
   logic [TOTAL_BITS-1:0] bal_after_coin;
   logic [TOTAL_BITS-1:0] bal_nxt;
   logic                  activity;

   logic [NUM_COINS-1:0]  pick_coin;
   logic [TOTAL_BITS-1:0] pick_value;
   logic                  pick_valid;

   vm_change_picker #(
      .NUM_COINS  (NUM_COINS),
      .TOTAL_BITS (TOTAL_BITS)
   ) u_picker (
      .i_balance    (balance_q),
      .i_coin_value (i_coin_value),
      .o_coin       (pick_coin),
      .o_value      (pick_value),
      .o_valid      (pick_valid)
   );

   // Coin, availability and dispense decode, all judged on the pre-edge balance.
   always_comb begin
      available   = '0;
      coin_found  = 1'b0;
      coin_val    = '0;
      disp_found  = 1'b0;
      disp_onehot = '0;
      disp_price  = '0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
         available[i] = (i_item_price[i*TOTAL_BITS +: TOTAL_BITS] <= balance_q) &&
                        (state_q != RETURN);
      end
      for (int k = 0; k < NUM_COINS; k++) begin
         if (!coin_found && i_input_coin[k]) begin
            coin_found = 1'b1;
            coin_val   = i_coin_value[k*TOTAL_BITS +: TOTAL_BITS];
         end
      end
      for (int i = 0; i < NUM_ITEMS; i++) begin
         if (!disp_found && i_select_item[i] && available[i]) begin
            disp_found     = 1'b1;
            disp_onehot[i] = 1'b1;
            disp_price     = i_item_price[i*TOTAL_BITS +: TOTAL_BITS];
         end
      end
      // Extra bit catches overflow so a wrapped balance is never stored.
      coin_sum       = {1'b0, balance_q} + {1'b0, coin_val};
      coin_accept    = coin_found && !coin_sum[TOTAL_BITS] && (state_q != RETURN);
      bal_after_coin = coin_accept ? coin_sum[TOTAL_BITS-1:0] : balance_q;
      // Price <= old balance <= bal_after_coin, so this cannot underflow.
      bal_nxt        = bal_after_coin - (disp_found ? disp_price : '0);
      activity       = coin_accept || disp_found;
   end

   always_comb begin
      state_d       = state_q;
      balance_d     = balance_q;
      timer_d       = timer_q;
      output_item_d = '0;
      return_coin_d = '0;
      coin_reject_d = 1'b0;
      case (state_q)
         IDLE: begin
            balance_d     = bal_nxt;
            output_item_d = disp_onehot;
            coin_reject_d = coin_found && !coin_accept;
            if (activity) begin
               timer_d = TIMER_RELOAD;
               if (bal_nxt != '0) begin
                  state_d = ACTIVE;
               end
            end
         end
         ACTIVE: begin
            balance_d     = bal_nxt;
            output_item_d = disp_onehot;
            coin_reject_d = coin_found && !coin_accept;
            if (activity) begin
               timer_d = TIMER_RELOAD;
            end else if (timer_q != '0) begin
               timer_d = timer_q - TIMER_ONE;
            end
            if (bal_nxt == '0) begin
               state_d = IDLE;
            end else if (i_trigger_return) begin
               state_d = RETURN;
            end else if (!activity && (timer_q == TIMER_ONE)) begin
               state_d = RETURN;
            end
         end
         RETURN: begin
            coin_reject_d = coin_found;
            timer_d       = '0;
            if (pick_valid) begin
               balance_d     = balance_q - pick_value;
               return_coin_d = pick_coin;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         balance_q     <= '0;
         timer_q       <= '0;
         output_item_q <= '0;
         return_coin_q <= '0;
         coin_reject_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         balance_q     <= balance_d;
         timer_q       <= timer_d;
         output_item_q <= output_item_d;
         return_coin_q <= return_coin_d;
         coin_reject_q <= coin_reject_d;
      end
   end

   assign o_available_item = available;
   assign o_output_item    = output_item_q;
   assign o_return_coin    = return_coin_q;
   assign o_current_total  = balance_q;
   assign o_coin_reject    = coin_reject_q;
   assign o_returning      = (state_q == RETURN);

endmodule

// File: tb/tb_vending_controller_param.sv
// Bench for vending_controller_param: a 31-bit instance (a_*) and an 11-bit
// instance (b_*) share stimulus; a cycle model per instance predicts every
// output, and directed steps pin specific values by hand.
module tb_vending_controller_param;

   localparam int NC   = 3;
   localparam int NI   = 4;
   localparam int WAIT = 100;
   localparam int TBA  = 31;
   localparam int TBB  = 11;

   int coin_v [NC] = '{100, 500, 1000};
   int price  [NI] = '{400, 500, 1000, 2000};

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [NC-1:0] in_coin = '0;
   logic [NI-1:0] in_sel = '0;
   logic in_trig = 1'b0;
   logic [NC*TBA-1:0] cv_a;
   logic [NI*TBA-1:0] pr_a;
   logic [NC*TBB-1:0] cv_b;
   logic [NI*TBB-1:0] pr_b;

   logic [NI-1:0]  a_avail, a_item, b_avail, b_item;
   logic [NC-1:0]  a_rcoin, b_rcoin;
   logic [TBA-1:0] a_total;
   logic [TBB-1:0] b_total;
   logic a_rej, a_ret, b_rej, b_ret;

   int errors = 0;
   int checks = 0;
   bit started = 1'b0;

   always #5 clk = ~clk;

   initial begin
      for (int k = 0; k < NC; k++) begin
         cv_a[k*TBA +: TBA] = TBA'(coin_v[k]);
         cv_b[k*TBB +: TBB] = TBB'(coin_v[k]);
      end
      for (int i = 0; i < NI; i++) begin
         pr_a[i*TBA +: TBA] = TBA'(price[i]);
         pr_b[i*TBB +: TBB] = TBB'(price[i]);
      end
   end

   vending_controller_param #(.NUM_COINS(NC), .NUM_ITEMS(NI), .TOTAL_BITS(TBA), .WAIT_CYCLES(WAIT)) dut_a (
      .clk(clk), .reset(reset), .i_input_coin(in_coin), .i_select_item(in_sel),
      .i_trigger_return(in_trig), .i_coin_value(cv_a), .i_item_price(pr_a),
      .o_available_item(a_avail), .o_output_item(a_item), .o_return_coin(a_rcoin),
      .o_current_total(a_total), .o_coin_reject(a_rej), .o_returning(a_ret));

   vending_controller_param #(.NUM_COINS(NC), .NUM_ITEMS(NI), .TOTAL_BITS(TBB), .WAIT_CYCLES(WAIT)) dut_b (
      .clk(clk), .reset(reset), .i_input_coin(in_coin), .i_select_item(in_sel),
      .i_trigger_return(in_trig), .i_coin_value(cv_b), .i_item_price(pr_b),
      .o_available_item(b_avail), .o_output_item(b_item), .o_return_coin(b_rcoin),
      .o_current_total(b_total), .o_coin_reject(b_rej), .o_returning(b_ret));

   // Model: balance as an integer, a "paying out" flag, a "session open"
   // flag and a count of consecutive quiet cycles since the last activity.
   typedef struct {
      longint        bal;
      bit            ret;
      bit            act;
      int            idle;
      logic [NI-1:0] item;
      logic [NC-1:0] rcoin;
      bit            rej;
   } mdl_t;

   localparam mdl_t M_RESET = '{bal: 0, ret: 0, act: 0, idle: 0, item: '0, rcoin: '0, rej: 0};

   mdl_t ma = M_RESET;
   mdl_t mb = M_RESET;

   function automatic mdl_t mstep(mdl_t s, logic [NC-1:0] c, logic [NI-1:0] sel, bit trig, int bits);
      mdl_t   n;
      longint limit;
      longint add;
      longint sub;
      int     best;
      int     ck;
      int     dk;
      bit     busy;
      n       = s;
      n.item  = '0;
      n.rcoin = '0;
      n.rej   = 0;
      limit   = longint'(1) << bits;
      if (s.ret) begin
         n.rej = (c != '0);
         best  = -1;
         for (int k = 0; k < NC; k++)
            if (coin_v[k] != 0 && coin_v[k] <= s.bal && (best < 0 || coin_v[k] > coin_v[best]))
               best = k;
         if (best >= 0) begin
            n.bal         = s.bal - coin_v[best];
            n.rcoin[best] = 1'b1;
         end else begin
            n.ret = 0;
         end
      end else begin
         ck = -1;
         for (int k = 0; k < NC; k++)
            if (ck < 0 && c[k]) ck = k;
         add = 0;
         if (ck >= 0) begin
            if (s.bal + coin_v[ck] < limit) add = coin_v[ck];
            else n.rej = 1;
         end
         dk = -1;
         for (int i = 0; i < NI; i++)
            if (dk < 0 && sel[i] && price[i] <= s.bal) dk = i;
         sub = 0;
         if (dk >= 0) begin
            sub        = price[dk];
            n.item[dk] = 1'b1;
         end
         n.bal = s.bal + add - sub;
         busy  = (ck >= 0 && !n.rej) || dk >= 0;
         if (s.act) begin
            if (n.bal == 0) begin
               n.act = 0;
            end else if (trig) begin
               n.act = 0;
               n.ret = 1;
            end else if (busy) begin
               n.idle = 0;
            end else begin
               n.idle = s.idle + 1;
               if (n.idle == WAIT) begin
                  n.act = 0;
                  n.ret = 1;
               end
            end
         end else if (busy && n.bal != 0) begin
            n.act  = 1;
            n.idle = 0;
         end
      end
      return n;
   endfunction

   function automatic logic [NI-1:0] mavail(mdl_t s);
      logic [NI-1:0] r;
      r = '0;
      for (int i = 0; i < NI; i++) r[i] = !s.ret && (price[i] <= s.bal);
      return r;
   endfunction

   always @(posedge clk) begin
      started <= 1'b1;
      if (reset) begin
         ma <= M_RESET;
         mb <= M_RESET;
      end else begin
         ma <= mstep(ma, in_coin, in_sel, in_trig, TBA);
         mb <= mstep(mb, in_coin, in_sel, in_trig, TBB);
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         chk("a_total",  longint'(a_total), ma.bal);
         chk("a_ret",    longint'(a_ret),   longint'(ma.ret));
         chk("a_item",   longint'(a_item),  longint'(ma.item));
         chk("a_rcoin",  longint'(a_rcoin), longint'(ma.rcoin));
         chk("a_rej",    longint'(a_rej),   longint'(ma.rej));
         chk("a_avail",  longint'(a_avail), longint'(mavail(ma)));
         chk("b_total",  longint'(b_total), mb.bal);
         chk("b_ret",    longint'(b_ret),   longint'(mb.ret));
         chk("b_item",   longint'(b_item),  longint'(mb.item));
         chk("b_rcoin",  longint'(b_rcoin), longint'(mb.rcoin));
         chk("b_rej",    longint'(b_rej),   longint'(mb.rej));
         chk("b_avail",  longint'(b_avail), longint'(mavail(mb)));
      end
   end

   // Drive one cycle of inputs starting at a falling edge, return at the next.
   task automatic step(input logic [NC-1:0] c, input logic [NI-1:0] s, input bit t);
      in_coin = c;
      in_sel  = s;
      in_trig = t;
      @(negedge clk);
      in_coin = '0;
      in_sel  = '0;
      in_trig = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("rst_total", longint'(a_total), 0);
      chk("rst_ret", longint'(a_ret), 0);

      // Trigger with nothing inserted does nothing.
      step(3'b000, 4'b0000, 1'b1);
      chk("idle_trig_ret", longint'(a_ret), 0);

      // 1: buy item1 with a 1000 coin.
      do_reset();
      step(3'b100, 4'b0000, 1'b0);
      chk("t1_total", longint'(a_total), 1000);
      chk("t1_avail", longint'(a_avail), 4'b0111);
      step(3'b000, 4'b0010, 1'b0);
      chk("t1_item", longint'(a_item), 4'b0010);
      chk("t1_bal", longint'(a_total), 500);
      step(3'b000, 4'b0000, 1'b0);
      chk("t1_item_drop", longint'(a_item), 0);

      // 2: idle timeout returns change exactly WAIT cycles after the coin.
      do_reset();
      step(3'b010, 4'b0000, 1'b0);
      for (int n = 0; n < WAIT - 1; n++) step(3'b000, 4'b0000, 1'b0);
      chk("t2_not_yet", longint'(a_ret), 0);
      step(3'b000, 4'b0000, 1'b0);
      chk("t2_ret", longint'(a_ret), 1);
      step(3'b000, 4'b0000, 1'b0);
      chk("t2_rcoin", longint'(a_rcoin), 3'b010);
      chk("t2_bal", longint'(a_total), 0);
      step(3'b000, 4'b0000, 1'b0);
      chk("t2_idle", longint'(a_ret), 0);
      chk("t2_rcoin_drop", longint'(a_rcoin), 0);

      // 3: 1700 paid back greedily.
      do_reset();
      step(3'b100, 4'b0000, 1'b0);
      step(3'b010, 4'b0000, 1'b0);
      step(3'b001, 4'b0000, 1'b0);
      step(3'b001, 4'b0000, 1'b0);
      chk("t3_total", longint'(a_total), 1700);
      step(3'b000, 4'b0000, 1'b1);
      chk("t3_ret", longint'(a_ret), 1);
      step(3'b000, 4'b0000, 1'b0);
      chk("t3_c0", longint'(a_rcoin), 3'b100);
      step(3'b000, 4'b0000, 1'b0);
      chk("t3_c1", longint'(a_rcoin), 3'b010);
      step(3'b000, 4'b0000, 1'b0);
      chk("t3_c2", longint'(a_rcoin), 3'b001);
      step(3'b000, 4'b0000, 1'b0);
      chk("t3_c3", longint'(a_rcoin), 3'b001);
      chk("t3_bal", longint'(a_total), 0);
      step(3'b000, 4'b0000, 1'b0);

      // 4: coin and select together; availability uses the old balance.
      do_reset();
      for (int n = 0; n < 4; n++) step(3'b001, 4'b0000, 1'b0);
      chk("t4_total", longint'(a_total), 400);
      step(3'b001, 4'b0001, 1'b0);
      chk("t4_item", longint'(a_item), 4'b0001);
      chk("t4_bal", longint'(a_total), 100);
      step(3'b001, 4'b0010, 1'b0);
      chk("t4_no_item", longint'(a_item), 0);
      chk("t4_bal2", longint'(a_total), 200);

      // 5: overflow reject on the 11-bit instance, and reject during RETURN.
      do_reset();
      step(3'b100, 4'b0000, 1'b0);
      step(3'b010, 4'b0000, 1'b0);
      chk("t5_b_total", longint'(b_total), 1500);
      step(3'b100, 4'b0000, 1'b0);
      chk("t5_b_rej", longint'(b_rej), 1);
      chk("t5_b_bal", longint'(b_total), 1500);
      chk("t5_a_acc", longint'(a_total), 2500);
      step(3'b000, 4'b0000, 1'b0);
      chk("t5_b_rej_drop", longint'(b_rej), 0);
      step(3'b000, 4'b0000, 1'b1);
      chk("t5_b_ret", longint'(b_ret), 1);
      step(3'b001, 4'b0000, 1'b0);
      chk("t5_b_rej_ret", longint'(b_rej), 1);
      chk("t5_b_rcoin", longint'(b_rcoin), 3'b100);
      chk("t5_b_bal2", longint'(b_total), 500);
      for (int n = 0; n < 4; n++) step(3'b000, 4'b0000, 1'b0);

      // 6: reset mid-RETURN discards the remaining balance.
      do_reset();
      step(3'b100, 4'b0000, 1'b0);
      step(3'b010, 4'b0000, 1'b0);
      step(3'b001, 4'b0000, 1'b0);
      step(3'b000, 4'b0000, 1'b1);
      step(3'b000, 4'b0000, 1'b0);
      chk("t6_rcoin", longint'(a_rcoin), 3'b100);
      chk("t6_bal", longint'(a_total), 600);
      do_reset();
      chk("t6_rst_bal", longint'(a_total), 0);
      chk("t6_rst_ret", longint'(a_ret), 0);
      chk("t6_rst_rcoin", longint'(a_rcoin), 0);
      step(3'b000, 4'b0000, 1'b0);
      chk("t6_quiet", longint'(a_rcoin), 0);
      step(3'b000, 4'b0000, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
